mano_ctrl_sequencer: RTL

- Control sequencer for the Mano basic computer. It owns the sequence counter (SC), the start/stop flip-flop S, the interrupt-enable flag IEN and the interrupt flag R.
- Produces one-hot timing T[7:0], a latched opcode decode D[7:0], the latched indirect bit I, and the fetch, indirect and interrupt-cycle strobes for the AR/PC/IR/TR/memory datapath.
- Execute-phase register micro-ops remain in the datapath, gated by t, d, i_flag and ir_in.

---
 rtl/mano_ctrl_pkg.sv | 43 ++++
 rtl/mano_ctrl_sequencer_onehot_dec3.sv | 9 +
 rtl/mano_ctrl_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mano_ctrl_pkg.sv
// Shared constants for the Mano basic-computer control sequencer:
// counter width, opcode indices, per-opcode last timing state and IR bit positions.
package mano_ctrl_pkg;

    localparam int unsigned SC_W = 3;
    localparam int unsigned OP_W = 3;

    localparam int unsigned D_AND = 0;
    localparam int unsigned D_ADD = 1;
    localparam int unsigned D_LDA = 2;
    localparam int unsigned D_STA = 3;
    localparam int unsigned D_BUN = 4;
    localparam int unsigned D_BSA = 5;
    localparam int unsigned D_ISZ = 6;
    localparam int unsigned D_IO  = 7;

    localparam int unsigned T_LAST_AND = 5;
    localparam int unsigned T_LAST_STA = 4;
    localparam int unsigned T_LAST_BUN = 4;
    localparam int unsigned T_LAST_BSA = 5;
    localparam int unsigned T_LAST_ISZ = 6;
    localparam int unsigned T_LAST_REG = 3;

    localparam int unsigned IR_HLT = 0;
    localparam int unsigned IR_IOF = 6;
    localparam int unsigned IR_ION = 7;
    localparam int unsigned IR_I   = 15;

    // Timing state in which each opcode finishes and SC clears.
    function automatic logic [SC_W-1:0] last_t(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(D_AND): last_t = SC_W'(T_LAST_AND);
            OP_W'(D_ADD): last_t = SC_W'(T_LAST_AND);
            OP_W'(D_LDA): last_t = SC_W'(T_LAST_AND);
            OP_W'(D_STA): last_t = SC_W'(T_LAST_STA);
            OP_W'(D_BUN): last_t = SC_W'(T_LAST_BUN);
            OP_W'(D_BSA): last_t = SC_W'(T_LAST_BSA);
            OP_W'(D_ISZ): last_t = SC_W'(T_LAST_ISZ);
            default:      last_t = SC_W'(T_LAST_REG);
        endcase
    endfunction

endpackage

// File: rtl/mano_ctrl_sequencer_onehot_dec3.sv
// Pure 3-to-8 one-hot decoder; input 0 yields 8'h01.
module onehot_dec3 (
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    assign onehot = 8'(1) << sel;

endmodule

// File: rtl/mano_ctrl_sequencer.sv
// Mano basic-computer control sequencer: SC, S, IEN, R, latched opcode/indirect bit,
// and the fetch / indirect / interrupt-cycle strobes for the address datapath.
module mano_ctrl_sequencer
    import mano_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir_in,
    input  logic        fgi,
    input  logic        fgo,
    output logic [7:0]  t,
    output logic [7:0]  d,
    output logic        i_flag,
    output logic        running,
    output logic        ien,
    output logic        r_flag,
    output logic        ar_from_pc,
    output logic        ir_load,
    output logic        pc_inr,
    output logic        ar_from_ir,
    output logic        ar_from_mem,
    output logic        mem_rd,
    output logic        ar_clr,
    output logic        tr_from_pc,
    output logic        mem_wr_tr,
    output logic        pc_clr
);

    logic [SC_W-1:0] sc_q, sc_nxt;
    logic [OP_W-1:0] op_q, op_nxt;
    logic            s_q, s_nxt;
    logic            ien_q, ien_nxt;
    logic            r_q, r_nxt;
    logic            i_q, i_nxt;
    logic            sc_clr;
    logic            fetch, intr;
    logic [7:0]      t_raw, d_raw;
    logic            unused_ir;

    assign unused_ir = ^{ir_in[11:8], ir_in[5:1]};

    onehot_dec3 u_t_dec (.sel(sc_q), .onehot(t_raw));
    onehot_dec3 u_d_dec (.sel(op_q), .onehot(d_raw));

    assign fetch = s_q & ~r_q;
    assign intr  = s_q & r_q;

    assign t       = s_q ? t_raw : 8'h00;
    assign d       = s_q ? d_raw : 8'h00;
    assign i_flag  = i_q;
    assign running = s_q;
    assign ien     = ien_q;
    assign r_flag  = r_q;

    // Fetch and indirect-address strobes
    assign ar_from_pc  = fetch & t_raw[0];
    assign ir_load     = fetch & t_raw[1];
    assign pc_inr      = (fetch & t_raw[1]) | (intr & t_raw[2]);
    assign ar_from_ir  = fetch & t_raw[2];
    assign ar_from_mem = s_q & t_raw[3] & ~d_raw[D_IO] & i_q;
    assign mem_rd      = ir_load | ar_from_mem;

    // Interrupt-cycle strobes
    assign ar_clr      = intr & t_raw[0];
    assign tr_from_pc  = intr & t_raw[0];
    assign mem_wr_tr   = intr & t_raw[1];
    assign pc_clr      = intr & t_raw[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q  <= '0;
            op_q  <= '0;
            s_q   <= 1'b0;
            ien_q <= 1'b0;
            r_q   <= 1'b0;
            i_q   <= 1'b0;
        end else begin
            sc_q  <= sc_nxt;
            op_q  <= op_nxt;
            s_q   <= s_nxt;
            ien_q <= ien_nxt;
            r_q   <= r_nxt;
            i_q   <= i_nxt;
        end
    end

    always_comb begin
        sc_nxt  = sc_q;
        op_nxt  = op_q;
        s_nxt   = s_q;
        ien_nxt = ien_q;
        r_nxt   = r_q;
        i_nxt   = i_q;
        sc_clr  = 1'b0;

        if (!s_q) begin
            sc_nxt = '0;
            s_nxt  = start;
        end else begin
            // End of interrupt cycle, end of instruction, or a stray T7
            sc_clr = (intr && t_raw[2])
                  || (sc_q >= SC_W'(T_LAST_REG) && sc_q == last_t(op_q))
                  || (&sc_q);

            if (fetch && t_raw[2]) begin
                op_nxt = ir_in[14:12];
                i_nxt  = ir_in[IR_I];
            end

            if (t_raw[3] && d_raw[D_IO]) begin
                if (!i_q && ir_in[IR_HLT])
                    s_nxt = 1'b0;
                if (i_q && ir_in[IR_IOF])
                    ien_nxt = 1'b0;
                else if (i_q && ir_in[IR_ION])
                    ien_nxt = 1'b1;
            end

            if (intr && t_raw[2]) begin
                ien_nxt = 1'b0;
                r_nxt   = 1'b0;
            end

            // SC gating keeps a fresh ION from interrupting its own instruction
            if (ien_q && (fgi || fgo) && sc_q >= SC_W'(T_LAST_REG))
                r_nxt = 1'b1;

            sc_nxt = sc_clr ? '0 : sc_q + SC_W'(1);
        end
    end

endmodule
